// File: rtl/hline_axi_burst_master.sv
// AXI4 burst master answering the hline_zbuff fsm level rd_req/wr_req handshake.
// Runs one fixed-length INCR burst per request and streams beats to/from the FIFOs.
module hline_axi_burst_master #(
    parameter int unsigned BURST_LEN = 16,
    parameter int unsigned CNT_W     = 8
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic        rd_req,
    input  logic        wr_req,
    input  logic [31:0] addr,
    output logic        done,
    output logic        err,
    output logic        rd_fifo_wr,
    input  logic        rd_fifo_full,
    output logic        wr_fifo_rd,
    input  logic        wr_fifo_empty,
    output logic [31:0] m_araddr,
    output logic        m_arvalid,
    input  logic        m_arready,
    input  logic [1:0]  m_rresp,
    input  logic        m_rlast,
    input  logic        m_rvalid,
    output logic        m_rready,
    output logic [31:0] m_awaddr,
    output logic        m_awvalid,
    input  logic        m_awready,
    output logic        m_wlast,
    output logic        m_wvalid,
    input  logic        m_wready,
    input  logic [1:0]  m_bresp,
    input  logic        m_bvalid,
    output logic        m_bready
);

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

    typedef enum logic [2:0] {
        IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, WR_RESP, DONE
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [31:0]       addr_q;
    logic              is_last;
    logic              r_beat;
    logic              w_beat;

    assign is_last = (cnt == LAST_BEAT);

    // Data-phase handshakes must follow FIFO status in the same cycle.
    assign m_rready   = (state == RD_DATA) && !rd_fifo_full;
    assign r_beat     = m_rready && m_rvalid;
    assign rd_fifo_wr = r_beat;
    assign m_wvalid   = (state == WR_DATA) && !wr_fifo_empty;
    assign w_beat     = m_wvalid && m_wready;
    assign wr_fifo_rd = w_beat;
    assign m_wlast    = m_wvalid && is_last;

    assign m_arvalid = (state == RD_ADDR);
    assign m_awvalid = (state == WR_ADDR);
    assign m_bready  = (state == WR_RESP);
    assign done      = (state == DONE);
    assign m_araddr  = addr_q;
    assign m_awaddr  = addr_q;

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state  <= IDLE;
            cnt    <= '0;
            addr_q <= '0;
            err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (rd_req || wr_req) begin
                        state  <= rd_req ? RD_ADDR : WR_ADDR;
                        addr_q <= addr & 32'hFFFF_FFFC;
                        cnt    <= '0;
                        err    <= 1'b0;
                    end
                end
                RD_ADDR: if (m_arready) state <= RD_DATA;
                RD_DATA: begin
                    if (r_beat) begin
                        // rlast mismatch is flagged but the burst still runs to its full length
                        if (m_rresp != 2'b00 || m_rlast != is_last) err <= 1'b1;
                        if (is_last) state <= DONE;
                        else         cnt   <= cnt + CNT_W'(1);
                    end
                end
                WR_ADDR: if (m_awready) state <= WR_DATA;
                WR_DATA: begin
                    if (w_beat) begin
                        if (is_last) state <= WR_RESP;
                        else         cnt   <= cnt + CNT_W'(1);
                    end
                end
                WR_RESP: begin
                    if (m_bvalid) begin
                        if (m_bresp != 2'b00) err <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: if (!rd_req && !wr_req) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
